// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC accumulator datapath.
package mac_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'b00,
      DRAIN = 2'b01,
      DONE  = 2'b10
   } mac_state_t;

   localparam int DEFAULT_ACC_W     = 16;
   localparam int DEFAULT_MAX_BEATS = 15;

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator adder: ACC_W-bit sum plus zero-extended 8-bit product, with carry out.
// Define MAC_SATURATE_EN to clamp the sum to all-ones on carry instead of wrapping.
module mac_sat_add #(
   parameter int ACC_W = 16
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [7:0]       addend,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] raw;

   assign raw   = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, addend};
   assign carry = raw[ACC_W];

`ifdef MAC_SATURATE_EN
   assign sum = carry ? '1 : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/multiplier_4_bit.sv
// Unsigned 4x4 array multiplier: shifted AND partial products summed into an 8-bit product.
module multiplier_4_bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [7:0] pp [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pp[i] = 8'({4{b[i]}} & a) << i;
      end
      p = pp[0] + pp[1] + pp[2] + pp[3];
   end

endmodule

// File: rtl/mac_accumulator_4bit.sv
// Burst multiply-accumulate stage: sums 4x4 products per burst and reports one result per burst.
// Optional MAC_SATURATE_EN (see mac_sat_add) selects saturating instead of wrapping accumulation.
module mac_accumulator_4bit
   import mac_pkg::*;
#(
   parameter  int ACC_W     = DEFAULT_ACC_W,
   parameter  int MAX_BEATS = DEFAULT_MAX_BEATS,
   localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] beat_count,
   output logic             overflow
);

   mac_state_t       state;
   logic [3:0]       op_a;
   logic [3:0]       op_b;
   logic             pend;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [7:0]       product;
   logic [ACC_W-1:0] sum;
   logic             carry;
   logic             accept;
   logic             burst_end;

   multiplier_4_bit u_mult (
      .a (op_a),
      .b (op_b),
      .p (product)
   );

   mac_sat_add #(.ACC_W(ACC_W)) u_add (
      .acc    (acc),
      .addend (product),
      .sum    (sum),
      .carry  (carry)
   );

   assign in_ready  = (state == ACCUM) && !rst;
   assign accept    = in_valid && in_ready;
   assign burst_end = in_last || ((cnt + CNT_W'(1)) == CNT_W'(MAX_BEATS));

   // Operands are registered on accept and their product is folded in one cycle later,
   // so DRAIN exists only to absorb the last pending product before reporting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         op_a      <= '0;
         op_b      <= '0;
         pend      <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         pend <= accept;
         if (accept) begin
            op_a <= a;
            op_b <= b;
         end
         if (pend) begin
            acc <= sum;
            if (carry) begin
               ovf <= 1'b1;
            end
         end
         case (state)
            ACCUM: begin
               if (accept) begin
                  cnt <= cnt + CNT_W'(1);
                  if (burst_end) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign acc_out    = acc;
   assign beat_count = cnt;
   assign overflow   = ovf;

endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// Randomized and directed bench for mac_accumulator_4bit against an arithmetic burst model.
module tb_mac_accumulator_4bit;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] in_valid;
   logic [1:0] in_last;
   logic [1:0] out_ready;
   logic [3:0] a [2];
   logic [3:0] b [2];
   logic [1:0] in_ready;
   logic [1:0] out_valid;
   logic [1:0] overflow;
   logic [15:0] acc0;
   logic [7:0]  acc1;
   logic [3:0]  cnt0;
   logic [2:0]  cnt1;

   int checks = 0;
   int errors = 0;
   int op_a [16];
   int op_b [16];

   always #5 clk = ~clk;

   mac_accumulator_4bit dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[0]),
      .in_ready   (in_ready[0]),
      .a          (a[0]),
      .b          (b[0]),
      .in_last    (in_last[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready[0]),
      .acc_out    (acc0),
      .beat_count (cnt0),
      .overflow   (overflow[0])
   );

   // Narrow instance so wrap/saturation and the beat cap are reachable.
   mac_accumulator_4bit #(.ACC_W(8), .MAX_BEATS(4)) dut_small (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[1]),
      .in_ready   (in_ready[1]),
      .a          (a[1]),
      .b          (b[1]),
      .in_last    (in_last[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready[1]),
      .acc_out    (acc1),
      .beat_count (cnt1),
      .overflow   (overflow[1])
   );

   function automatic int accOf(input int idx);
      return (idx == 0) ? int'(acc0) : int'(acc1);
   endfunction

   function automatic int cntOf(input int idx);
      return (idx == 0) ? int'(cnt0) : int'(cnt1);
   endfunction

   function automatic int accWidthOf(input int idx);
      return (idx == 0) ? 16 : 8;
   endfunction

   function automatic int maxBeatsOf(input int idx);
      return (idx == 0) ? 15 : 4;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Sends one burst from op_a/op_b, then checks the reported result against plain arithmetic.
   task automatic applyStimulus(input int idx, input int n, input bit withLast,
                                input bit gaps, input int hold);
      int    maxB;
      int    nSend;
      longint maxV;
      longint expAcc;
      bit    expOvf;
      int    waited;
      maxB   = maxBeatsOf(idx);
      nSend  = (withLast && n <= maxB) ? n : maxB;
      maxV   = (longint'(1) << accWidthOf(idx)) - 1;
      expAcc = 0;
      expOvf = 1'b0;
      for (int k = 0; k < nSend; k++) begin
         expAcc += longint'(op_a[k] * op_b[k]);
         if (expAcc > maxV) begin
            expOvf = 1'b1;
`ifdef MAC_SATURATE_EN
            expAcc = maxV;
`else
            expAcc -= maxV + 1;
`endif
         end
      end

      for (int k = 0; k < nSend; k++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
               a[idx]       = 4'($urandom);
               b[idx]       = 4'($urandom);
               in_last[idx] = 1'($urandom);
               step();
            end
         end
         in_valid[idx] = 1'b1;
         a[idx]        = 4'(op_a[k]);
         b[idx]        = 4'(op_b[k]);
         in_last[idx]  = withLast && (k == n - 1);
         waited = 0;
         while (!in_ready[idx] && waited < 50) begin
            step();
            waited++;
         end
         if (!in_ready[idx]) begin
            checkOutput("in_ready timeout", 0, 1);
            in_valid[idx] = 1'b0;
            return;
         end
         step();
         in_valid[idx] = 1'b0;
         in_last[idx]  = 1'b0;
      end

      checkOutput("out_valid at T+1", int'(out_valid[idx]), 0);
      step();
      checkOutput("out_valid at T+2", int'(out_valid[idx]), 1);
      checkOutput("acc_out", accOf(idx), int'(expAcc));
      checkOutput("beat_count", cntOf(idx), nSend);
      checkOutput("overflow", int'(overflow[idx]), int'(expOvf));

      repeat (hold) begin
         in_valid[idx] = 1'b1;
         a[idx]        = 4'($urandom);
         b[idx]        = 4'($urandom);
         step();
         checkOutput("held out_valid", int'(out_valid[idx]), 1);
         checkOutput("held acc_out", accOf(idx), int'(expAcc));
         checkOutput("held in_ready", int'(in_ready[idx]), 0);
      end
      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b1;
      step();
      out_ready[idx] = 1'b0;
      checkOutput("out_valid released", int'(out_valid[idx]), 0);
      checkOutput("in_ready after release", int'(in_ready[idx]), 1);
      checkOutput("acc cleared", accOf(idx), 0);
   endtask

   task automatic loadOps(input int k, input int va, input int vb);
      op_a[k] = va;
      op_b[k] = vb;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_last   = '0;
      out_ready = '0;
      for (int i = 0; i < 2; i++) begin
         a[i] = '0;
         b[i] = '0;
      end
      repeat (3) step();
      checkOutput("in_ready during reset", int'(in_ready[0]), 0);
      rst = 1'b0;
      #1;
      checkOutput("reset acc_out", accOf(0), 0);
      checkOutput("reset beat_count", cntOf(0), 0);
      checkOutput("reset overflow", int'(overflow[0]), 0);
      checkOutput("reset out_valid", int'(out_valid[0]), 0);
      checkOutput("in_ready after reset", int'(in_ready[0]), 1);

      $display("[TB] three-beat burst");
      loadOps(0, 3, 5); loadOps(1, 15, 15); loadOps(2, 2, 7);
      applyStimulus(0, 3, 1'b1, 1'b0, 0);

      $display("[TB] output backpressure");
      applyStimulus(0, 3, 1'b1, 1'b0, 5);
      loadOps(0, 1, 1);
      applyStimulus(0, 1, 1'b1, 1'b0, 0);

      $display("[TB] narrow accumulator overflow");
      loadOps(0, 15, 15); loadOps(1, 15, 15);
      applyStimulus(1, 2, 1'b1, 1'b0, 0);

      $display("[TB] beat cap without last");
      for (int k = 0; k < 4; k++) loadOps(k, 1, 1);
      applyStimulus(1, 4, 1'b0, 1'b0, 3);

      $display("[TB] reset mid-burst");
      in_valid[0] = 1'b1;
      a[0]        = 4'd4;
      b[0]        = 4'd4;
      in_last[0]  = 1'b0;
      step();
      step();
      in_valid[0] = 1'b0;
      rst         = 1'b1;
      #1;
      checkOutput("in_ready with rst high", int'(in_ready[0]), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("abort acc_out", accOf(0), 0);
      checkOutput("abort beat_count", cntOf(0), 0);
      checkOutput("abort overflow", int'(overflow[0]), 0);
      checkOutput("abort out_valid", int'(out_valid[0]), 0);
      loadOps(0, 2, 3);
      applyStimulus(0, 1, 1'b1, 1'b0, 0);

      $display("[TB] zero single beat");
      loadOps(0, 0, 0);
      applyStimulus(0, 1, 1'b1, 1'b0, 0);

      $display("[TB] randomized bursts");
      for (int t = 0; t < 24; t++) begin
         int idx;
         int n;
         idx = $urandom_range(0, 1);
         n   = $urandom_range(1, 16);
         for (int k = 0; k < 16; k++) loadOps(k, $urandom_range(0, 15), $urandom_range(0, 15));
         applyStimulus(idx, n, 1'($urandom_range(0, 3) != 0), 1'b1, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
